// File: rtl/draw_card.sv
// draw_card: sweeps a 16x16 playing card one pixel per clock into the VGA write port.
// Optional build macro CARD_BACK_PATTERN_EN turns the face-down interior into a checkerboard.
module draw_card #(
  parameter logic [2:0] BORDER_COLOUR = 3'b111,
  parameter logic [2:0] FACE_COLOUR   = 3'b111,
  parameter logic [2:0] PIP_COLOUR    = 3'b100,
  parameter logic [2:0] BACK_COLOUR   = 3'b001
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       start,
  input  logic [7:0] x0,
  input  logic [6:0] y0,
  input  logic       face_up,
  input  logic [3:0] value,
  output logic [7:0] x,
  output logic [6:0] y,
  output logic [2:0] colour,
  output logic       plot,
  output logic       busy,
  output logic       done
);

  typedef enum logic [1:0] {IDLE, DRAW, DONE} state_t;

  state_t     r_state;
  logic [7:0] r_cnt;
  logic [7:0] r_x0;
  logic [6:0] r_y0;
  logic       r_face;
  logic [3:0] r_value;

  logic [7:0] w_nextCnt;
  logic [3:0] w_col;
  logic [3:0] w_row;
  logic [7:0] w_baseX;
  logic [6:0] w_baseY;
  logic       w_face;
  logic [3:0] w_value;
  logic [7:0] w_nextX;
  logic [6:0] w_nextY;
  logic [2:0] w_nextColour;

  // Pip grid lookup along one axis: {valid, index}; pips occupy 2-pixel bands 2-3, 5-6, 8-9, 11-12.
  function automatic logic [2:0] f_grid(input logic [3:0] p);
    case (p)
      4'd2, 4'd3:   f_grid = 3'b100;
      4'd5, 4'd6:   f_grid = 3'b101;
      4'd8, 4'd9:   f_grid = 3'b110;
      4'd11, 4'd12: f_grid = 3'b111;
      default:      f_grid = 3'b000;
    endcase
  endfunction

  function automatic logic [2:0] f_pixel(input logic [3:0] col, input logic [3:0] row,
                                         input logic face, input logic [3:0] val);
    logic [2:0] gc;
    logic [2:0] gr;
    logic [2:0] c;
    gc = f_grid(col);
    gr = f_grid(row);
    if (col == 4'd0 || col == 4'd15 || row == 4'd0 || row == 4'd15) begin
      c = BORDER_COLOUR;
    end else if (face) begin
      if (gc[2] && gr[2] && ({gr[1:0], gc[1:0]} < val))
        c = PIP_COLOUR;
      else
        c = FACE_COLOUR;
    end else begin
`ifdef CARD_BACK_PATTERN_EN
      c = (col[0] ^ row[0]) ? 3'b000 : BACK_COLOUR;
`else
      c = BACK_COLOUR;
`endif
    end
    f_pixel = c;
  endfunction

  // In IDLE the first pixel is built straight from the inputs so it appears the cycle after start.
  assign w_nextCnt    = (r_state == IDLE) ? 8'd0 : r_cnt + 8'd1;
  assign w_col        = w_nextCnt[3:0];
  assign w_row        = w_nextCnt[7:4];
  assign w_baseX      = (r_state == IDLE) ? x0 : r_x0;
  assign w_baseY      = (r_state == IDLE) ? y0 : r_y0;
  assign w_face       = (r_state == IDLE) ? face_up : r_face;
  assign w_value      = (r_state == IDLE) ? value : r_value;
  assign w_nextX      = w_baseX + {4'b0000, w_col};
  assign w_nextY      = w_baseY + {3'b000, w_row};
  assign w_nextColour = f_pixel(w_col, w_row, w_face, w_value);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= IDLE;
      r_cnt   <= 8'd0;
      r_x0    <= 8'd0;
      r_y0    <= 7'd0;
      r_face  <= 1'b0;
      r_value <= 4'd0;
      x       <= 8'd0;
      y       <= 7'd0;
      colour  <= 3'd0;
      plot    <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          plot <= 1'b0;
          done <= 1'b0;
          busy <= 1'b0;
          if (start) begin
            r_x0    <= x0;
            r_y0    <= y0;
            r_face  <= face_up;
            r_value <= value;
            r_cnt   <= w_nextCnt;
            x       <= w_nextX;
            y       <= w_nextY;
            colour  <= w_nextColour;
            plot    <= 1'b1;
            busy    <= 1'b1;
            r_state <= DRAW;
          end
        end
        DRAW: begin
          if (r_cnt == 8'd255) begin
            plot    <= 1'b0;
            done    <= 1'b1;
            r_state <= DONE;
          end else begin
            r_cnt  <= w_nextCnt;
            x      <= w_nextX;
            y      <= w_nextY;
            colour <= w_nextColour;
            plot   <= 1'b1;
          end
        end
        DONE: begin
          done    <= 1'b0;
          busy    <= 1'b0;
          r_cnt   <= 8'd0;
          r_state <= IDLE;
        end
        default: begin
          plot    <= 1'b0;
          busy    <= 1'b0;
          done    <= 1'b0;
          r_state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_draw_card.sv
// tb_draw_card: directed checks of the draw_card pixel sweep, handshake and reset behaviour.
module tb_draw_card;

  logic       clk;
  logic       reset_n;
  logic       start;
  logic [7:0] x0;
  logic [6:0] y0;
  logic       face_up;
  logic [3:0] value;
  logic [7:0] x;
  logic [6:0] y;
  logic [2:0] colour;
  logic       plot;
  logic       busy;
  logic       done;

  int testsRun;
  int testsFailed;

  logic [7:0] capX [256];
  logic [6:0] capY [256];
  logic [2:0] capC [256];
  int plotCount;
  int doneCount;
  int busyCount;
  int firstPlotK;
  int lastPlotK;
  int doneK;
  int consecutive;

  draw_card dut (
    .clk     (clk),
    .reset_n (reset_n),
    .start   (start),
    .x0      (x0),
    .y0      (y0),
    .face_up (face_up),
    .value   (value),
    .x       (x),
    .y       (y),
    .colour  (colour),
    .plot    (plot),
    .busy    (busy),
    .done    (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Independent restatement of the pip rule using divide/modulo arithmetic.
  function automatic int pipIndex(input int col, input int row);
    int pc;
    int pr;
    pipIndex = -1;
    if (col >= 2 && col <= 12 && ((col - 2) % 3) != 2 &&
        row >= 2 && row <= 12 && ((row - 2) % 3) != 2) begin
      pc = (col - 2) / 3;
      pr = (row - 2) / 3;
      pipIndex = 4 * pr + pc;
    end
  endfunction

  // Starts one draw and records every plotted pixel over a fixed 300-cycle window.
  task automatic run_draw(input logic [7:0] ax, input logic [6:0] ay, input logic af,
                          input logic [3:0] av, input int injectAt);
    @(negedge clk);
    x0 = ax; y0 = ay; face_up = af; value = av; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    plotCount = 0; doneCount = 0; busyCount = 0;
    firstPlotK = -1; lastPlotK = -1; doneK = -1; consecutive = 1;
    for (int k = 1; k <= 300; k++) begin
      if (k > 1) @(negedge clk);
      #1;
      if (plot) begin
        if (plotCount < 256) begin
          capX[plotCount] = x;
          capY[plotCount] = y;
          capC[plotCount] = colour;
        end
        plotCount++;
        if (firstPlotK < 0) firstPlotK = k;
        if (lastPlotK >= 0 && k != lastPlotK + 1) consecutive = 0;
        lastPlotK = k;
      end
      if (done) begin
        doneCount++;
        doneK = k;
      end
      if (busy) busyCount++;
      if (k == injectAt) begin
        start = 1'b1;
        x0 = 8'd0;
      end else if (k == injectAt + 1) begin
        start = 1'b0;
      end
    end
  endtask

  task automatic test_reset;
    reset_n = 1'b0; start = 1'b0; x0 = 8'd0; y0 = 7'd0; face_up = 1'b0; value = 4'd0;
    #23;
    testsRun++;
    if ({plot, busy, done} !== 3'b000) begin
      testsFailed++;
      $display("[TB] FAIL reset_ctrl: got plot/busy/done=%b expected 000", {plot, busy, done});
    end
    testsRun++;
    if ({x, y, colour} !== 18'd0) begin
      testsFailed++;
      $display("[TB] FAIL reset_pixel: got x=%0d y=%0d colour=%0d expected 0 0 0", x, y, colour);
    end
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  task automatic test_basic_draw;
    run_draw(8'd10, 7'd20, 1'b1, 4'd5, -10);
    testsRun++;
    if (firstPlotK !== 1) begin
      testsFailed++;
      $display("[TB] FAIL first_latency: got cycle %0d expected 1", firstPlotK);
    end
    testsRun++;
    if (plotCount !== 256 || consecutive !== 1) begin
      testsFailed++;
      $display("[TB] FAIL plot_count: got %0d (consecutive=%0d) expected 256 (1)", plotCount, consecutive);
    end
    testsRun++;
    if (doneCount !== 1 || doneK !== 257) begin
      testsFailed++;
      $display("[TB] FAIL done_pulse: got count=%0d cycle=%0d expected 1 at 257", doneCount, doneK);
    end
    testsRun++;
    if (busyCount !== 257) begin
      testsFailed++;
      $display("[TB] FAIL busy_len: got %0d expected 257", busyCount);
    end
    testsRun++;
    if (capX[0] !== 8'd10 || capY[0] !== 7'd20 || capC[0] !== 3'b111) begin
      testsFailed++;
      $display("[TB] FAIL first_pixel: got (%0d,%0d) c=%0d expected (10,20) c=7", capX[0], capY[0], capC[0]);
    end
    testsRun++;
    if (capX[255] !== 8'd25 || capY[255] !== 7'd35) begin
      testsFailed++;
      $display("[TB] FAIL last_pixel: got (%0d,%0d) expected (25,35)", capX[255], capY[255]);
    end
    testsRun++;
    if (capX[34] !== 8'd12 || capY[34] !== 7'd22 || capC[34] !== 3'b100) begin
      testsFailed++;
      $display("[TB] FAIL pip0: got (%0d,%0d) c=%0d expected (12,22) c=4", capX[34], capY[34], capC[34]);
    end
    testsRun++;
    if (capX[43] !== 8'd21 || capC[43] !== 3'b100) begin
      testsFailed++;
      $display("[TB] FAIL pip3: got x=%0d c=%0d expected x=21 c=4", capX[43], capC[43]);
    end
    testsRun++;
    if (capY[82] !== 7'd25 || capC[82] !== 3'b100) begin
      testsFailed++;
      $display("[TB] FAIL pip4: got y=%0d c=%0d expected y=25 c=4", capY[82], capC[82]);
    end
    testsRun++;
    if (capX[85] !== 8'd15 || capC[85] !== 3'b111) begin
      testsFailed++;
      $display("[TB] FAIL pip5_unlit: got x=%0d c=%0d expected x=15 c=7", capX[85], capC[85]);
    end
    testsRun++;
    if (capX[36] !== 8'd14 || capC[36] !== 3'b111) begin
      testsFailed++;
      $display("[TB] FAIL gap_col4: got x=%0d c=%0d expected x=14 c=7", capX[36], capC[36]);
    end
  endtask

  task automatic test_wrap_back;
    run_draw(8'd250, 7'd120, 1'b0, 4'd0, -10);
    testsRun++;
    if (capX[5] !== 8'd255 || capX[6] !== 8'd0 || capX[15] !== 8'd9) begin
      testsFailed++;
      $display("[TB] FAIL x_wrap: got %0d,%0d,%0d expected 255,0,9", capX[5], capX[6], capX[15]);
    end
    testsRun++;
    if (capY[112] !== 7'd127 || capY[128] !== 7'd0 || capY[255] !== 7'd7) begin
      testsFailed++;
      $display("[TB] FAIL y_wrap: got %0d,%0d,%0d expected 127,0,7", capY[112], capY[128], capY[255]);
    end
    testsRun++;
    if (capX[17] !== 8'd251 || capY[17] !== 7'd121 || capC[17] !== 3'b001) begin
      testsFailed++;
      $display("[TB] FAIL back_c1r1: got (%0d,%0d) c=%0d expected (251,121) c=1", capX[17], capY[17], capC[17]);
    end
    testsRun++;
`ifdef CARD_BACK_PATTERN_EN
    if (capC[18] !== 3'b000) begin
      testsFailed++;
      $display("[TB] FAIL back_c2r1: got c=%0d expected 0", capC[18]);
    end
`else
    if (capC[18] !== 3'b001) begin
      testsFailed++;
      $display("[TB] FAIL back_c2r1: got c=%0d expected 1", capC[18]);
    end
`endif
    testsRun++;
    if (capC[0] !== 3'b111 || capC[240] !== 3'b111) begin
      testsFailed++;
      $display("[TB] FAIL back_border: got c=%0d,%0d expected 7,7", capC[0], capC[240]);
    end
  endtask

  task automatic test_start_ignored;
    run_draw(8'd40, 7'd10, 1'b1, 4'd3, 50);
    testsRun++;
    if (plotCount !== 256 || doneCount !== 1) begin
      testsFailed++;
      $display("[TB] FAIL restart_count: got plots=%0d dones=%0d expected 256 1", plotCount, doneCount);
    end
    testsRun++;
    if (capX[60] !== 8'd52 || capX[255] !== 8'd55 || capY[255] !== 7'd25) begin
      testsFailed++;
      $display("[TB] FAIL restart_origin: got x60=%0d last=(%0d,%0d) expected 52 (55,25)",
               capX[60], capX[255], capY[255]);
    end
  endtask

  task automatic test_values;
    int pipPix;
    int bad;
    int col;
    int row;
    int idx;
    logic [2:0] expC;
    run_draw(8'd0, 7'd0, 1'b1, 4'd0, -10);
    pipPix = 0;
    for (int i = 0; i < 256; i++) if (capC[i] === 3'b100) pipPix++;
    testsRun++;
    if (pipPix !== 0) begin
      testsFailed++;
      $display("[TB] FAIL value0_pips: got %0d pip pixels expected 0", pipPix);
    end
    run_draw(8'd0, 7'd0, 1'b1, 4'd15, -10);
    bad = 0;
    for (int i = 0; i < 256; i++) begin
      col = i % 16;
      row = i / 16;
      idx = pipIndex(col, row);
      if (col == 0 || col == 15 || row == 0 || row == 15) expC = 3'b111;
      else if (idx >= 0 && idx < 15) expC = 3'b100;
      else expC = 3'b111;
      if (capC[i] !== expC) bad++;
    end
    testsRun++;
    if (bad !== 0) begin
      testsFailed++;
      $display("[TB] FAIL value15_grid: got %0d wrong pixels expected 0", bad);
    end
    testsRun++;
    if (capC[187] !== 3'b111 || capC[140] !== 3'b100) begin
      testsFailed++;
      $display("[TB] FAIL value15_pip15: got c11r11=%0d c12r8=%0d expected 7 4", capC[187], capC[140]);
    end
  endtask

  task automatic test_back_to_back;
    logic doneAt257;
    logic plotAt258;
    logic plotAt259;
    int waitCycles;
    doneAt257 = 1'b0; plotAt258 = 1'b1; plotAt259 = 1'b0;
    @(negedge clk);
    x0 = 8'd5; y0 = 7'd5; face_up = 1'b1; value = 4'd1; start = 1'b1;
    for (int k = 1; k <= 259; k++) begin
      @(negedge clk);
      #1;
      if (k == 257) doneAt257 = done;
      if (k == 258) plotAt258 = plot;
      if (k == 259) plotAt259 = plot;
    end
    start = 1'b0;
    testsRun++;
    if ({doneAt257, plotAt258, plotAt259} !== 3'b101) begin
      testsFailed++;
      $display("[TB] FAIL back_to_back: got done257/plot258/plot259=%b expected 101",
               {doneAt257, plotAt258, plotAt259});
    end
    waitCycles = 0;
    while (busy && waitCycles < 400) begin
      @(negedge clk);
      #1;
      waitCycles++;
    end
    testsRun++;
    if (busy !== 1'b0) begin
      testsFailed++;
      $display("[TB] FAIL b2b_timeout: got busy=%b expected 0", busy);
    end
  endtask

  task automatic test_midreset;
    int strayPlots;
    @(negedge clk);
    x0 = 8'd30; y0 = 7'd30; face_up = 1'b1; value = 4'd2; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int k = 2; k <= 101; k++) @(negedge clk);
    #1;
    testsRun++;
    if (plot !== 1'b1 || busy !== 1'b1) begin
      testsFailed++;
      $display("[TB] FAIL midreset_pre: got plot=%b busy=%b expected 1 1", plot, busy);
    end
    #1;
    reset_n = 1'b0;
    #1;
    testsRun++;
    if ({plot, busy, done} !== 3'b000) begin
      testsFailed++;
      $display("[TB] FAIL midreset_async: got plot/busy/done=%b expected 000", {plot, busy, done});
    end
    @(negedge clk);
    reset_n = 1'b1;
    strayPlots = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      #1;
      if (plot || busy) strayPlots++;
    end
    testsRun++;
    if (strayPlots !== 0) begin
      testsFailed++;
      $display("[TB] FAIL midreset_idle: got %0d active cycles expected 0", strayPlots);
    end
  endtask

  initial begin
    testsRun = 0;
    testsFailed = 0;
    test_reset;
    test_basic_draw;
    test_wrap_back;
    test_start_ignored;
    test_values;
    test_back_to_back;
    test_midreset;
    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
